// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit. Every operation takes a fixed 34 cycles.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] ScrA,
  input  logic [31:0] ScrB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [31:0] ma, mb;
  logic        sa, sb;
  logic [63:0] acc;
  logic [32:0] rem;
  logic        a_neg, b_neg;
  logic [31:0] am, bm;
  logic [32:0] msum, shin;
  logic [33:0] dsub;
  logic [63:0] prod;
  logic [31:0] quo, rmd, fix_res;
  always_comb begin
    a_neg   = ScrA[31] & (funct3[2] ? ~funct3[0] : funct3[1:0] != 2'b11);
    b_neg   = ScrB[31] & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    am      = a_neg ? -ScrA : ScrA;
    bm      = b_neg ? -ScrB : ScrB;
    msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
    shin    = {rem[31:0], acc[31]};
    dsub    = {1'b0, shin} - {2'b0, mb};
    prod    = (sa ^ sb) ? -acc : acc;
    // the restoring loop yields an all-ones quotient for a zero divisor, but its sign fix must be bypassed
    quo     = (mb == 32'd0) ? 32'hFFFF_FFFF : (sa ^ sb) ? -acc[31:0] : acc[31:0];
    rmd     = sa ? -rem[31:0] : rem[31:0];
    fix_res = op[2] ? (op[1] ? rmd : quo) : (op[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      op     <= 3'd0;
      ma     <= 32'd0;
      mb     <= 32'd0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc    <= 64'd0;
      rem    <= 33'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op    <= funct3;
          sa    <= a_neg;
          sb    <= b_neg;
          ma    <= am;
          mb    <= bm;
          acc   <= {32'd0, funct3[2] ? am : bm};
          rem   <= 33'd0;
          cnt   <= 5'd0;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          if (op[2]) begin
            rem        <= dsub[33] ? shin : dsub[32:0];
            acc[31:0]  <= {acc[30:0], ~dsub[33]};
          end else acc <= {msum, acc[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit covering latency, signedness, special cases and handshake.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] ScrA, ScrB;
  logic        busy, done;
  logic [31:0] result;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] sb_q[$];

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .ScrA(ScrA), .ScrB(ScrB), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    funct3 = f;
    ScrA   = a;
    ScrB   = b;
    start  = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; ScrA = 32'd0; ScrB = 32'd0;
    repeat (3) @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset done: got %b want 0", done); end
    compared++; if (result !== 32'd0) begin mismatched++; $display("FAIL reset result: got %h want 0", result); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] exp;
    launch(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b busy after start: got %b want 1", busy); end
    wait_done(1, lat);
    exp = sb_q.pop_front();
    compared++; if (result !== exp) begin mismatched++; $display("FAIL b2b mul result: got %h want %h", result, exp); end
    compared++; if (lat != 34) begin mismatched++; $display("FAIL b2b mul latency: got %0d want 34", lat); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b busy in done: got %b want 0", busy); end
    launch(3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL b2b done pulse width: got %b want 0", done); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL b2b restart busy: got %b want 1", busy); end
    wait_done(1, lat);
    exp = sb_q.pop_front();
    compared++; if (result !== exp) begin mismatched++; $display("FAIL b2b mulh result: got %h want %h", result, exp); end
    compared++; if (lat != 34) begin mismatched++; $display("FAIL b2b mulh latency: got %0d want 34", lat); end
  endtask

  task automatic test_mul_high;
    logic [98:0] t [4];
    int lat;
    logic [31:0] exp;
    t = '{{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
          {3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
          {3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
          {3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001}};
    foreach (t[i]) begin
      launch(t[i][98:96], t[i][95:64], t[i][63:32], t[i][31:0]);
      wait_done(1, lat);
      exp = sb_q.pop_front();
      compared++; if (result !== exp) begin mismatched++; $display("FAIL mul_high[%0d] result: got %h want %h", i, result, exp); end
      compared++; if (lat != 34) begin mismatched++; $display("FAIL mul_high[%0d] latency: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_divide;
    logic [98:0] t [6];
    int lat;
    logic [31:0] exp;
    t = '{{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
          {3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
          {3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC},
          {3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001},
          {3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD},
          {3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001}};
    foreach (t[i]) begin
      launch(t[i][98:96], t[i][95:64], t[i][63:32], t[i][31:0]);
      wait_done(1, lat);
      exp = sb_q.pop_front();
      compared++; if (result !== exp) begin mismatched++; $display("FAIL divide[%0d] result: got %h want %h", i, result, exp); end
      compared++; if (lat != 34) begin mismatched++; $display("FAIL divide[%0d] latency: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_special;
    logic [98:0] t [7];
    int lat;
    logic [31:0] exp;
    t = '{{3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF},
          {3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
          {3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF},
          {3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF},
          {3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9},
          {3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
          {3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}};
    foreach (t[i]) begin
      launch(t[i][98:96], t[i][95:64], t[i][63:32], t[i][31:0]);
      wait_done(1, lat);
      exp = sb_q.pop_front();
      compared++; if (result !== exp) begin mismatched++; $display("FAIL special[%0d] result: got %h want %h", i, result, exp); end
      compared++; if (lat != 34) begin mismatched++; $display("FAIL special[%0d] latency: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_handshake;
    int lat;
    int extra;
    logic [31:0] exp;
    launch(3'b101, 32'd100, 32'd7, 32'd14);
    repeat (2) @(negedge clk);
    ScrA = 32'hDEAD_BEEF;
    funct3 = 3'b000;
    repeat (2) @(negedge clk);
    start = 1'b1; ScrA = 32'd5; ScrB = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    exp = sb_q.pop_front();
    compared++; if (result !== exp) begin mismatched++; $display("FAIL handshake result: got %h want %h", result, exp); end
    compared++; if (lat != 34) begin mismatched++; $display("FAIL handshake latency: got %0d want 34", lat); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    compared++; if (extra != 0) begin mismatched++; $display("FAIL handshake extra done: got %0d want 0", extra); end
    compared++; if (result !== exp) begin mismatched++; $display("FAIL handshake hold: got %h want %h", result, exp); end
  endtask

  task automatic test_reset_mid;
    int extra;
    logic [31:0] drop;
    launch(3'b000, 32'd3, 32'd5, 32'd15);
    drop = sb_q.pop_back();
    repeat (9) @(negedge clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL reset_mid busy before: got %b want 1", busy); end
    @(posedge clk);
    reset = 1'b1;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_mid done: got %b want 0", done); end
    compared++; if (result !== 32'd0) begin mismatched++; $display("FAIL reset_mid result: got %h want 0 (dropped %h)", result, drop); end
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    compared++; if (extra != 0) begin mismatched++; $display("FAIL reset_mid late done: got %0d want 0", extra); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_mul_high;
    test_divide;
    test_special;
    test_handshake;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
